// File: rtl/cafe_pkg.sv
// cafe_pkg -- shared definitions for the coffee-machine FSM (maquina_maluca)
// and its sequence checker.
//   cafe_state_t : 4-bit brew-FSM state encoding (0 and 10..15 are invalid)
//   ERR_*        : err_code values reported by cafe_seq_checker
//   mon_state_t  : checker monitor FSM encoding
//   is_valid_state() : true for encodings 1..9
package cafe_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd1,
        LIGAR     = 4'd2,
        VERIFICAR = 4'd3,
        ENCHER    = 4'd4,
        MOER      = 4'd5,
        COLOCAR   = 4'd6,
        PASSAR    = 4'd7,
        TAMPEAR   = 4'd8,
        EXTRACAO  = 4'd9
    } cafe_state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL  = 3'd1;
    localparam logic [2:0] ERR_ENCODING = 3'd2;
    localparam logic [2:0] ERR_REFILL   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_SPURIOUS = 3'd5;
    localparam logic [2:0] ERR_MISSED   = 3'd6;

    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_ACTIVE = 2'd1,
        M_ERR    = 2'd2
    } mon_state_t;

    function automatic logic is_valid_state(input logic [3:0] s);
        return (s >= 4'd1) && (s <= 4'd9);
    endfunction

endpackage

// File: rtl/cafe_trans_legal.sv
// cafe_trans_legal -- combinational legality check of one observed brew-FSM
// transition.
//   i_prev_state : state sampled on the previous edge
//   i_state      : state sampled on this edge
//   i_start_q    : start sampled on the previous edge
//   o_legal      : 1 when the pair is allowed by the brew graph
//   o_err_code   : ERR_NONE when legal, otherwise the highest-priority cause
//                  among encoding / spurious start / missed start / illegal
module cafe_trans_legal
    import cafe_pkg::*;
(
    input  logic [3:0] i_prev_state,
    input  logic [3:0] i_state,
    input  logic       i_start_q,
    output logic       o_legal,
    output logic [2:0] o_err_code
);

    logic       w_edge_ok;
    logic [2:0] w_code;

    // Pure graph adjacency; start qualification for IDLE is applied below.
    always_comb begin
        w_edge_ok = 1'b0;
        case (i_prev_state)
            IDLE:      w_edge_ok = (i_state == IDLE) || (i_state == LIGAR);
            LIGAR:     w_edge_ok = (i_state == VERIFICAR);
            VERIFICAR: w_edge_ok = (i_state == ENCHER) || (i_state == MOER);
            ENCHER:    w_edge_ok = (i_state == VERIFICAR);
            MOER:      w_edge_ok = (i_state == COLOCAR);
            COLOCAR:   w_edge_ok = (i_state == PASSAR);
            PASSAR:    w_edge_ok = (i_state == TAMPEAR);
            TAMPEAR:   w_edge_ok = (i_state == EXTRACAO);
            EXTRACAO:  w_edge_ok = (i_state == IDLE);
            default:   w_edge_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_code = ERR_NONE;
        if (!is_valid_state(i_state))
            w_code = ERR_ENCODING;
        else if ((i_prev_state == IDLE) && (i_state == LIGAR) && !i_start_q)
            w_code = ERR_SPURIOUS;
        else if ((i_prev_state == IDLE) && (i_state == IDLE) && i_start_q)
            w_code = ERR_MISSED;
        else if (!w_edge_ok)
            w_code = ERR_ILLEGAL;
    end

    assign o_err_code = w_code;
    assign o_legal    = (w_code == ERR_NONE);

endmodule

// File: rtl/cafe_seq_checker.sv
// cafe_seq_checker -- observer on the maquina_maluca state output. Checks each
// sampled transition against the brew graph, enforces refill and brew-length
// limits, counts completed brews and latches the first error.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : start request seen by the FSM
//   state      : observed FSM state
//   clr        : synchronous clear of error/err_code/err_state
//   error      : sticky error flag
//   err_code   : first error cause (cafe_pkg ERR_*)
//   err_state  : state value sampled when the error was detected
//   brew_done  : one-cycle pulse per completed brew
//   brew_count : completed brews, saturating at all-ones
//   busy       : brew in progress
//   hist       : last four sampled states, newest in [3:0]
//                (present only when CAFE_CHK_HIST_EN is defined)
module cafe_seq_checker
    import cafe_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned MAX_REFILL   = 3,
    parameter int unsigned MAX_BREW_CYC = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       state,
    input  logic             clr,
    output logic             error,
    output logic [2:0]       err_code,
    output logic [3:0]       err_state,
    output logic             brew_done,
    output logic [CNT_W-1:0] brew_count,
    output logic             busy
`ifdef CAFE_CHK_HIST_EN
    ,
    output logic [15:0]      hist
`endif
);

    localparam int unsigned REF_W = $clog2(MAX_REFILL + 2);
    localparam int unsigned CYC_W = $clog2(MAX_BREW_CYC + 1);
    localparam logic [REF_W-1:0] REF_LIMIT = REF_W'(MAX_REFILL);
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(MAX_BREW_CYC - 1);

    mon_state_t       r_mon;
    mon_state_t       w_mon_next;
    logic [3:0]       r_prev_state;
    logic             r_start_q;
    logic [REF_W-1:0] r_refill;
    logic [CYC_W-1:0] r_cyc;
    logic [2:0]       r_err_code;
    logic [3:0]       r_err_state;
    logic             r_brew_done;
    logic [CNT_W-1:0] r_brew_count;

    logic             w_pair_legal;
    logic [2:0]       w_pair_code;
    logic             w_check;
    logic             w_active;
    logic             w_brew_start;
    logic             w_brew_end;
    logic             w_refill_over;
    logic             w_timeout;
    logic [2:0]       w_err_code;
    logic             w_err;

    cafe_trans_legal u_trans_legal (
        .i_prev_state (r_prev_state),
        .i_state      (state),
        .i_start_q    (r_start_q),
        .o_legal      (w_pair_legal),
        .o_err_code   (w_pair_code)
    );

    always_comb begin
        // In M_ERR nothing is checked except on the clr edge, where a fresh
        // error must win over the clear.
        w_check       = (r_mon != M_ERR) || clr;
        w_active      = (r_mon == M_ACTIVE);
        w_brew_start  = (r_mon == M_IDLE) && w_pair_legal &&
                        (r_prev_state == IDLE) && (state == LIGAR);
        w_brew_end    = w_active && (r_prev_state == EXTRACAO) && (state == IDLE);
        w_refill_over = w_active && (state == ENCHER) && (r_refill == REF_LIMIT);
        // r_cyc+1 would reach MAX_BREW_CYC on this edge without finishing.
        w_timeout     = w_active && !w_brew_end && (r_cyc == CYC_LAST);

        w_err_code = ERR_NONE;
        if (!w_pair_legal)
            w_err_code = w_pair_code;
        else if (w_refill_over)
            w_err_code = ERR_REFILL;
        else if (w_timeout)
            w_err_code = ERR_TIMEOUT;

        w_err = w_check && (w_err_code != ERR_NONE);
    end

    // Monitor FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_mon <= M_IDLE;
        else
            r_mon <= w_mon_next;
    end

    // Monitor FSM: next state
    always_comb begin
        w_mon_next = r_mon;
        if (w_err) begin
            w_mon_next = M_ERR;
        end else begin
            case (r_mon)
                M_IDLE:   if (w_brew_start) w_mon_next = M_ACTIVE;
                M_ACTIVE: if (w_brew_end)   w_mon_next = M_IDLE;
                M_ERR:    if (clr)          w_mon_next = M_IDLE;
                default:                    w_mon_next = M_IDLE;
            endcase
        end
    end

    // Monitor FSM: outputs
    always_comb begin
        error = (r_mon == M_ERR);
        busy  = (r_mon == M_ACTIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_state <= IDLE;
            r_start_q    <= 1'b0;
            r_refill     <= '0;
            r_cyc        <= '0;
            r_err_code   <= '0;
            r_err_state  <= '0;
            r_brew_done  <= 1'b0;
            r_brew_count <= '0;
        end else begin
            r_prev_state <= state;
            r_start_q    <= start;

            if (w_brew_start) begin
                r_refill <= '0;
                r_cyc    <= '0;
            end else if (w_active) begin
                r_cyc <= r_cyc + CYC_W'(1);
                if (state == ENCHER)
                    r_refill <= r_refill + REF_W'(1);
            end

            if (w_err) begin
                r_err_code  <= w_err_code;
                r_err_state <= state;
            end else if (clr) begin
                r_err_code  <= '0;
                r_err_state <= '0;
            end

            // w_brew_end needs M_ACTIVE, so the count is frozen in M_ERR.
            r_brew_done <= w_brew_end;
            if (w_brew_end && (r_brew_count != '1))
                r_brew_count <= r_brew_count + CNT_W'(1);
        end
    end

    assign err_code   = r_err_code;
    assign err_state  = r_err_state;
    assign brew_done  = r_brew_done;
    assign brew_count = r_brew_count;

`ifdef CAFE_CHK_HIST_EN
    logic [15:0] r_hist;

    // The offending sample is still shifted in on the error-entry edge, so
    // the frozen window ends with the state that caused the error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_hist <= {4{4'(IDLE)}};
        else if (r_mon != M_ERR)
            r_hist <= {r_hist[11:0], state};
    end

    assign hist = r_hist;
`endif

endmodule

// File: tb/tb_cafe_seq_checker.sv
module tb_cafe_seq_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] state;
    logic       clr;

    logic       a_error, a_brew_done, a_busy;
    logic [2:0] a_err_code;
    logic [3:0] a_err_state;
    logic [1:0] a_brew_count;

    logic       t_error, t_brew_done, t_busy;
    logic [2:0] t_err_code;
    logic [3:0] t_err_state;
    logic [1:0] t_brew_count;

`ifdef CAFE_CHK_HIST_EN
    logic [15:0] a_hist, t_hist;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Main instance: long brew budget, 2-bit counter for saturation.
    cafe_seq_checker #(.CNT_W(2), .MAX_REFILL(3), .MAX_BREW_CYC(32)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .state      (state),
        .clr        (clr),
        .error      (a_error),
        .err_code   (a_err_code),
        .err_state  (a_err_state),
        .brew_done  (a_brew_done),
        .brew_count (a_brew_count),
        .busy       (a_busy)
`ifdef CAFE_CHK_HIST_EN
        ,
        .hist       (a_hist)
`endif
    );

    // Short-budget instance on the same stimulus, for timeout behaviour.
    cafe_seq_checker #(.CNT_W(2), .MAX_REFILL(3), .MAX_BREW_CYC(8)) u_dut_t (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .state      (state),
        .clr        (clr),
        .error      (t_error),
        .err_code   (t_err_code),
        .err_state  (t_err_state),
        .brew_done  (t_brew_done),
        .brew_count (t_brew_count),
        .busy       (t_busy)
`ifdef CAFE_CHK_HIST_EN
        ,
        .hist       (t_hist)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample, then return 1 time unit after the edge that took it.
    task automatic cyc(input logic [3:0] s, input logic st);
        state = s;
        start = st;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        state = 4'd1;
        start = 1'b0;
        clr   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        state = 4'd1;
        start = 1'b0;
        clr   = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({a_error, a_err_code, a_err_state, a_brew_done, a_brew_count, a_busy} !== 12'h000) begin
            n_fails++;
            $display("FAIL reset_outputs: got %03h want 000",
                     {a_error, a_err_code, a_err_state, a_brew_done, a_brew_count, a_busy});
        end
`ifdef CAFE_CHK_HIST_EN
        n_checks++;
        if (a_hist !== 16'h1111) begin
            n_fails++;
            $display("FAIL reset_hist: got %04h want 1111", a_hist);
        end
`endif
        rst = 1'b0;
        cyc(4'd1, 1'b0);
        n_checks++;
        if ({a_error, a_busy} !== 2'b00) begin
            n_fails++;
            $display("FAIL reset_idle_hold: got err/busy %b want 00", {a_error, a_busy});
        end
    endtask

    task automatic test_nominal();
        logic [3:0] seq [8] = '{4'd3, 4'd4, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        do_reset();
        cyc(4'd1, 1'b1);
        n_checks++;
        if (a_busy !== 1'b0) begin
            n_fails++;
            $display("FAIL nominal_busy_pre: got %b want 0", a_busy);
        end
        cyc(4'd2, 1'b0);
        n_checks++;
        if ({a_error, a_busy} !== 2'b01) begin
            n_fails++;
            $display("FAIL nominal_busy_ligar: got err/busy %b want 01", {a_error, a_busy});
        end
        for (int i = 0; i < 8; i++) begin
            cyc(seq[i], 1'b0);
            n_checks++;
            if ({a_error, a_busy, a_brew_done} !== 3'b010) begin
                n_fails++;
                $display("FAIL nominal_step%0d: got err/busy/done %b want 010", i, {a_error, a_busy, a_brew_done});
            end
        end
        cyc(4'd1, 1'b0);
        n_checks++;
        if ({a_brew_done, a_brew_count, a_busy, a_error} !== 5'b10100) begin
            n_fails++;
            $display("FAIL nominal_done: got done/cnt/busy/err %b want 10100",
                     {a_brew_done, a_brew_count, a_busy, a_error});
        end
        cyc(4'd1, 1'b0);
        n_checks++;
        if ({a_brew_done, a_brew_count} !== 3'b001) begin
            n_fails++;
            $display("FAIL nominal_pulse_end: got done/cnt %b want 001", {a_brew_done, a_brew_count});
        end
    endtask

    task automatic test_illegal_skip();
        do_reset();
        cyc(4'd1, 1'b1);
        cyc(4'd2, 1'b0);
        cyc(4'd5, 1'b0);
        n_checks++;
        if ({a_error, a_err_code, a_err_state, a_busy} !== {1'b1, 3'd1, 4'd5, 1'b0}) begin
            n_fails++;
            $display("FAIL skip_error: got err/code/state/busy %b/%0d/%0d/%b want 1/1/5/0",
                     a_error, a_err_code, a_err_state, a_busy);
        end
        // (5,1) is also illegal but must not overwrite the first error.
        cyc(4'd1, 1'b0);
        n_checks++;
        if ({a_error, a_err_code, a_err_state} !== {1'b1, 3'd1, 4'd5}) begin
            n_fails++;
            $display("FAIL skip_sticky: got err/code/state %b/%0d/%0d want 1/1/5",
                     a_error, a_err_code, a_err_state);
        end
`ifdef CAFE_CHK_HIST_EN
        n_checks++;
        if (a_hist !== 16'h1125) begin
            n_fails++;
            $display("FAIL skip_hist: got %04h want 1125", a_hist);
        end
`endif
        clr = 1'b1;
        cyc(4'd1, 1'b0);
        clr = 1'b0;
        n_checks++;
        if ({a_error, a_err_code, a_err_state} !== 8'h00) begin
            n_fails++;
            $display("FAIL skip_clr: got err/code/state %b/%0d/%0d want 0/0/0",
                     a_error, a_err_code, a_err_state);
        end
    endtask

    task automatic test_refill();
        logic [3:0] seq [7] = '{4'd3, 4'd4, 4'd3, 4'd4, 4'd3, 4'd4, 4'd3};
        do_reset();
        cyc(4'd1, 1'b1);
        cyc(4'd2, 1'b0);
        for (int i = 0; i < 7; i++) cyc(seq[i], 1'b0);
        n_checks++;
        if ({a_error, a_busy} !== 2'b01) begin
            n_fails++;
            $display("FAIL refill_three_ok: got err/busy %b want 01", {a_error, a_busy});
        end
        cyc(4'd4, 1'b0);
        n_checks++;
        if ({a_error, a_err_code, a_err_state} !== {1'b1, 3'd3, 4'd4}) begin
            n_fails++;
            $display("FAIL refill_limit: got err/code/state %b/%0d/%0d want 1/3/4",
                     a_error, a_err_code, a_err_state);
        end
        // Short-budget instance hits refill and timeout on the same edge.
        n_checks++;
        if ({t_error, t_err_code} !== {1'b1, 3'd3}) begin
            n_fails++;
            $display("FAIL refill_over_timeout_prio: got err/code %b/%0d want 1/3", t_error, t_err_code);
        end
    endtask

    task automatic test_start_errors();
        do_reset();
        cyc(4'd2, 1'b0);
        n_checks++;
        if ({a_error, a_err_code, a_err_state} !== {1'b1, 3'd5, 4'd2}) begin
            n_fails++;
            $display("FAIL spurious_start: got err/code/state %b/%0d/%0d want 1/5/2",
                     a_error, a_err_code, a_err_state);
        end
        cyc(4'd1, 1'b0);
        clr = 1'b1;
        cyc(4'd1, 1'b0);
        clr = 1'b0;
        cyc(4'd12, 1'b0);
        n_checks++;
        if ({a_error, a_err_code, a_err_state} !== {1'b1, 3'd2, 4'd12}) begin
            n_fails++;
            $display("FAIL invalid_encoding: got err/code/state %b/%0d/%0d want 1/2/12",
                     a_error, a_err_code, a_err_state);
        end
        cyc(4'd1, 1'b0);
        clr = 1'b1;
        cyc(4'd1, 1'b0);
        clr = 1'b0;
        cyc(4'd1, 1'b1);
        n_checks++;
        if (a_error !== 1'b0) begin
            n_fails++;
            $display("FAIL missed_pre: got err %b want 0", a_error);
        end
        cyc(4'd1, 1'b0);
        n_checks++;
        if ({a_error, a_err_code, a_err_state} !== {1'b1, 3'd6, 4'd1}) begin
            n_fails++;
            $display("FAIL missed_start: got err/code/state %b/%0d/%0d want 1/6/1",
                     a_error, a_err_code, a_err_state);
        end
        // clr coinciding with a new illegal pair (1,3): new error is latched.
        cyc(4'd1, 1'b0);
        clr = 1'b1;
        cyc(4'd3, 1'b0);
        clr = 1'b0;
        n_checks++;
        if ({a_error, a_err_code, a_err_state} !== {1'b1, 3'd1, 4'd3}) begin
            n_fails++;
            $display("FAIL clr_vs_new_error: got err/code/state %b/%0d/%0d want 1/1/3",
                     a_error, a_err_code, a_err_state);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] seq [6] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        logic [1:0] exp_cnt;
        int pulses;
        pulses = 0;
        do_reset();
        for (int b = 1; b <= 5; b++) begin
            cyc(4'd1, 1'b1);
            n_checks++;
            if (a_brew_done !== 1'b0) begin
                n_fails++;
                $display("FAIL sat_pulse_low%0d: got %b want 0", b, a_brew_done);
            end
            cyc(4'd2, 1'b0);
            for (int i = 0; i < 6; i++) cyc(seq[i], 1'b0);
            cyc(4'd1, 1'b0);
            if (a_brew_done === 1'b1) pulses++;
            exp_cnt = (b > 3) ? 2'd3 : 2'(b);
            n_checks++;
            if (a_brew_count !== exp_cnt) begin
                n_fails++;
                $display("FAIL sat_count%0d: got %0d want %0d", b, a_brew_count, exp_cnt);
            end
        end
        n_checks++;
        if (pulses != 5) begin
            n_fails++;
            $display("FAIL sat_pulses: got %0d want 5", pulses);
        end
        // A minimal brew (7 active edges) fits inside an 8-cycle budget.
        n_checks++;
        if ({t_error, t_brew_count} !== {1'b0, 2'd3}) begin
            n_fails++;
            $display("FAIL sat_short_budget: got err/cnt %b/%0d want 0/3", t_error, t_brew_count);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] seq [7] = '{4'd3, 4'd4, 4'd3, 4'd4, 4'd3, 4'd5, 4'd6};
        cyc(4'd1, 1'b1);
        cyc(4'd2, 1'b0);
        for (int i = 0; i < 7; i++) cyc(seq[i], 1'b0);
        n_checks++;
        if ({t_error, t_busy} !== 2'b01) begin
            n_fails++;
            $display("FAIL timeout_7th: got err/busy %b want 01", {t_error, t_busy});
        end
        cyc(4'd7, 1'b0);
        n_checks++;
        if ({t_error, t_err_code, t_err_state, t_busy} !== {1'b1, 3'd4, 4'd7, 1'b0}) begin
            n_fails++;
            $display("FAIL timeout_8th: got err/code/state/busy %b/%0d/%0d/%b want 1/4/7/0",
                     t_error, t_err_code, t_err_state, t_busy);
        end
        n_checks++;
        if ({a_error, a_busy, a_brew_count} !== {1'b0, 1'b1, 2'd3}) begin
            n_fails++;
            $display("FAIL timeout_long_budget: got err/busy/cnt %b/%b/%0d want 0/1/3",
                     a_error, a_busy, a_brew_count);
        end
        // Asynchronous reset mid-brew, checked before the next clock edge.
        state = 4'd8;
        rst   = 1'b1;
        #1;
        n_checks++;
        if ({a_error, a_err_code, a_err_state, a_brew_done, a_busy} !== 10'h000) begin
            n_fails++;
            $display("FAIL async_rst_a: got %03h want 000",
                     {a_error, a_err_code, a_err_state, a_brew_done, a_busy});
        end
        n_checks++;
        if (a_brew_count !== 2'd0) begin
            n_fails++;
            $display("FAIL async_rst_count: got %0d want 0", a_brew_count);
        end
        n_checks++;
        if ({t_error, t_err_code, t_err_state, t_brew_done, t_brew_count, t_busy} !== 12'h000) begin
            n_fails++;
            $display("FAIL async_rst_t: got %03h want 000",
                     {t_error, t_err_code, t_err_state, t_brew_done, t_brew_count, t_busy});
        end
        @(posedge clk);
        #1;
        state = 4'd1;
        rst   = 1'b0;
        cyc(4'd1, 1'b0);
        n_checks++;
        if ({a_error, a_busy, t_error, t_busy} !== 4'b0000) begin
            n_fails++;
            $display("FAIL post_rst_idle: got %b want 0000", {a_error, a_busy, t_error, t_busy});
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clr   = 1'b0;
        state = 4'd1;
        test_reset();
        test_nominal();
        test_illegal_skip();
        test_refill();
        test_start_errors();
        test_saturation();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cafe_seq_checker.md
Name: cafe_seq_checker

Overview:
- Synthesizable observer sitting on the 4-bit state output of the coffee-machine FSM (maquina_maluca); it is the consuming end of that interface.
- Samples state and start each clock, checks every transition against the legal brew graph, counts completed brews, and raises a sticky coded error.
- Used as an on-chip assertion block in hardware and as a self-checking monitor in simulation.

Parameters:
- CNT_W, 8: width of brew_count; saturates at all-ones.
- MAX_REFILL, 3: maximum ENCHER_RESERVATORIO visits allowed per brew.
- MAX_BREW_CYC, 32: maximum cycles from LIGAR_MAQUINA to return to IDLE.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  same start signal the FSM sees.
- state  in  4  FSM state being observed.
- clr  in  1  synchronous pulse; clears error, err_code, err_state.
- error  out  1  sticky error flag.
- err_code  out  3  first error cause.
- err_state  out  4  the offending state value.
- brew_done  out  1  one-cycle pulse per completed brew.
- brew_count  out  CNT_W  completed brews, saturating.
- busy  out  1  a brew is in progress.

Behaviour:
- State encodings (shared package): IDLE=1, LIGAR=2, VERIFICAR=3, ENCHER=4, MOER=5, COLOCAR=6, PASSAR=7, TAMPEAR=8, EXTRACAO=9. Values 0 and 10-15 are invalid.
- Registers prev_state and start_q capture state and start every edge.
  - Reset values: prev_state=IDLE, start_q=0.
  - Every output resets to 0.
- Each edge evaluates the pair (prev_state, state) with start_q. Any verdict is registered, so outputs appear one cycle after the offending state is first sampled.
- Legal transitions:
  - IDLE->IDLE only if start_q=0.
  - IDLE->LIGAR only if start_q=1.
  - LIGAR->VERIFICAR.
  - VERIFICAR->ENCHER or VERIFICAR->MOER.
  - ENCHER->VERIFICAR.
  - MOER->COLOCAR->PASSAR->TAMPEAR->EXTRACAO->IDLE.
  - Every other pair, including any self-hold outside IDLE, is illegal.
- err_code values:
  - 1: illegal transition.
  - 2: invalid encoding.
  - 3: refill limit exceeded.
  - 4: timeout.
  - 5: spurious start, meaning IDLE->LIGAR with start_q=0.
  - 6: missed start, meaning IDLE->IDLE with start_q=1.
- Priority when several errors occur on one edge: 2 > 5 > 6 > 1 > 3 > 4.
- Monitor FSM has three states:
  - M_IDLE goes to M_ACTIVE on a legal IDLE->LIGAR.
  - M_ACTIVE goes to M_IDLE on EXTRACAO->IDLE.
  - Any error from either state goes to M_ERR.
  - M_ERR goes to M_IDLE on clr. If clr and a new error coincide, the new error wins and is latched.
- busy=1 exactly while in M_ACTIVE.
- Refill counter: cleared on LIGAR and incremented on each ->ENCHER. If a ->ENCHER edge would bring it to MAX_REFILL+1, raise code 3.
- Cycle counter: cleared on LIGAR and incremented every active cycle. Raise code 4 when it reaches MAX_BREW_CYC while still active.
- On EXTRACAO->IDLE: brew_done pulses high for one cycle and brew_count increments, holding at 2^CNT_W-1 once there.
- Only the first error is latched into err_code and err_state; later errors are ignored until clr.
- While in M_ERR, transitions are still tracked in prev_state but not checked, and brew_count is frozen.
- Reset asserted mid-brew returns all registers to their reset values immediately. brew_count is not retained.

Optional Feature:
- Macro CAFE_CHK_HIST_EN.
- When defined: adds output hist[15:0], a shift register of the last four sampled states with the newest in [3:0]. It resets to {4{IDLE}} and freezes on error entry for post-mortem.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package cafe_pkg holds the state encoding localparams (IDLE..EXTRACAO), the err_code constants, and the monitor FSM encoding. maquina_maluca and this checker share it.
- One natural sub-module, cafe_trans_legal: combinational, takes (prev_state, state, start_q) and returns {legal, err_code}.
- Counters and the monitor FSM stay in the top module.

Test Plan:
- Nominal brew: reset, start=1 for one edge, FSM drives 2,3,4,3,5,6,7,8,9,1. Required: brew_done pulses one cycle after 1 is sampled, brew_count=1, error=0 throughout, busy high from the cycle after LIGAR until the cycle after IDLE.
- Illegal skip: drive 1,2,5 (VERIFICAR skipped). Required: error=1, err_code=1, err_state=5 one cycle later. A following clr returns error to 0.
- Refill limit with MAX_REFILL=3: drive 2,3,4,3,4,3,4,3,4. Required: err_code=3 after the fourth ENCHER is sampled.
- Spurious start and invalid encoding: with start=0 drive 1->2; required err_code=5. After clr, drive state=12; required err_code=2, err_state=12.
- Timeout with MAX_BREW_CYC=8: hold the sequence legal but stretched. Required: err_code=4 on the 8th active cycle. Assert rst mid-brew; required: all outputs 0 immediately and brew_count=0.
- Saturation with CNT_W=2: run 5 brews. Required: brew_count holds 3, brew_done pulses 5 times.
